// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - runtime-loadable serial pattern detector with toggle and saturating count
module seq_detect_param #(
  parameter int                 PAT_W   = 3,
  parameter logic [PAT_W-1:0]   PATTERN = 3'b110,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             match,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FW   = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]    FULL = FW'(PAT_W);
  localparam logic [CNT_W-1:0] ONES = '1;

  logic [PAT_W-1:0] pat_reg, pat_nxt;
  logic [PAT_W-1:0] sr, sr_nxt, sr_shift;
  logic [FW-1:0]    fill, fill_nxt, fill_inc;
  logic [CNT_W-1:0] cnt_base, cnt_nxt;
  logic             sat_base, sat_nxt;
  logic             accept, hit;

  always_comb begin
    sr_shift = {sr[PAT_W-2:0], in_bit};
    fill_inc = (fill == FULL) ? fill : fill + FW'(1);
    accept   = in_valid & ~pat_load;
    hit      = accept && (sr_shift == pat_reg) && (fill_inc == FULL);

    pat_nxt  = pat_reg;
    sr_nxt   = sr;
    fill_nxt = fill;
    if (pat_load) begin
      pat_nxt  = pat_in;
      sr_nxt   = '0;
      fill_nxt = '0;
    end else if (accept) begin
      sr_nxt   = sr_shift;
      // Non-overlap restarts the fill so the next match needs a full fresh pattern.
      fill_nxt = (hit && !overlap_en) ? '0 : fill_inc;
    end

    // A clear on the same edge as a match leaves exactly that match counted.
    cnt_base = cnt_clr ? '0 : match_cnt;
    sat_base = cnt_clr ? 1'b0 : cnt_sat;
    cnt_nxt  = cnt_base;
    if (hit && (cnt_base != ONES)) cnt_nxt = cnt_base + CNT_W'(1);
    sat_nxt  = sat_base | (cnt_nxt == ONES);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_reg   <= PATTERN;
      sr        <= '0;
      fill      <= '0;
      match     <= 1'b0;
      out       <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      pat_reg   <= pat_nxt;
      sr        <= sr_nxt;
      fill      <= fill_nxt;
      match     <= hit;
      if (hit) out <= ~out;
      match_cnt <= cnt_nxt;
      cnt_sat   <= sat_nxt;
    end
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector, the next generation of the team's fixed "110" toggle detector. It watches a qualified serial bit stream for a runtime-loadable pattern of PAT_W bits. It reports each match as a one-cycle pulse, a toggling level output and a saturating match count. Overlapping and non-overlapping detection are selectable at run time. It sits between a serial front end and control logic that needs event, parity-of-events and count information.

## Interface
- PAT_W, 3: pattern length in bits, 2..16.
- PATTERN, 3'b110: pattern register value after reset; the first-received bit is the MSB.
- CNT_W, 8: match counter width.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  reset: one clock, synchronous, active-low (0 = reset, sampled on rising edge of clk).
- in_valid  input  1  qualifies in_bit; bit accepted on an edge where in_valid=1.
- in_bit  input  1  serial data bit.
- overlap_en  input  1  1 = overlapping detection; 0 = non-overlapping.
- pat_load  input  1  loads pat_in into the pattern register and clears history.
- pat_in  input  PAT_W  new pattern, MSB first.
- cnt_clr  input  1  clears match_cnt and cnt_sat.
- match  output  1  one-cycle pulse per detected match.
- out  output  1  toggles on every match.
- match_cnt  output  CNT_W  saturating count of matches.
- cnt_sat  output  1  sticky; high once match_cnt has reached all-ones.

## Operation
- History: shift register sr[PAT_W-1:0]. On an accepted bit, sr <= {sr[PAT_W-2:0], in_bit}. Fill counter fill (0..PAT_W) increments, saturating at PAT_W.
- Match condition on an accepted bit: the new sr equals pat_reg and the new fill equals PAT_W. No match can occur until PAT_W bits have been accepted since reset, load or the last non-overlapping match.
- Overlap mode (overlap_en=1): after a match, sr and fill are kept, so trailing bits count toward the next match.
- Non-overlap mode (overlap_en=0): on a match, fill <= 0, so the next match needs PAT_W fresh bits.
- overlap_en is sampled on each accepted bit. A change takes effect from the next accepted bit and never alters current history.
- On a match:
  - match=1 for one cycle.
  - out <= ~out.
  - match_cnt <= match_cnt+1, unless already all-ones, in which case it holds.
  - cnt_sat <= 1 when the new value is all-ones.
- pat_load=1: pat_reg <= pat_in, fill <= 0, sr <= 0. Any in_bit on that edge is discarded, and no match occurs that cycle. out and match_cnt are unaffected.
- cnt_clr=1: match_cnt <= 0 and cnt_sat <= 0. If a match occurs on the same edge, match_cnt <= 1, and cnt_sat <= 1 only if CNT_W=1. match and out still respond.
- in_valid=0: no state changes except pat_load and cnt_clr effects. match=0.
- Priority on one edge: rst > pat_load > accepted bit. cnt_clr is independent of the others.

## Timing
- All outputs are registered. Reset values (rst=0 on an edge): match=0, out=0, match_cnt=0, cnt_sat=0, pat_reg=PATTERN, sr=0, fill=0.
- Latency: the bit completing the pattern is accepted on edge k. match, out, match_cnt and cnt_sat show the result after edge k, and match is valid for exactly that one cycle.
- Back-to-back matches are possible every cycle in overlap mode, e.g. pattern all-ones with a continuous 1 input. out then toggles every cycle.
- Reset asserted mid-pattern discards the partial history. Detection restarts from an empty history on the first accepted bit after rst returns high. pat_reg returns to PATTERN.
- in_valid gaps do not break a pattern. Only accepted bits count.

## Test plan
- Default 110, overlap_en=0, stream 1,1,0,1,1,0 with in_valid=1 → match pulses after bits 3 and 6; out 0→1→0; match_cnt=2.
- Load pat_in=3'b101, stream 1,0,1,0,1 → overlap_en=1: matches after bits 3 and 5, match_cnt=2. overlap_en=0: a match after bit 3 only, match_cnt=1.
- Stream 1,1,0 with in_valid low for 3 cycles between each bit → single match one cycle after the third accepted bit; match=0 during the gaps.
- CNT_W=2, overlap_en=1, pattern 111, nine consecutive 1s → 7 matches; match_cnt sticks at 3 and cnt_sat=1 from the 3rd match; out=1 after the 7 toggles. cnt_clr then gives 0/0.
- Send 1,1; assert rst=0 for one cycle; send 0,1,1,0 → exactly one match, after the final 0.
- Send 1,1; pulse pat_load with pat_in=3'b011 while in_valid=1, in_bit=0 → that bit is discarded, no match. Sending 0,1,1 then gives a match after the last 1.
